// File: rtl/bitonic_unloader.sv
// Drain stage of the bitonic sort pipeline: buffers up to two sorted vectors and
// serialises them one element per valid/ready handshake, dropping vectors when full.
module bitonic_unloader #(
    parameter int LOG_INPUT  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int LSB_FIRST  = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                x_valid,
    input  logic [DATA_WIDTH*(1<<LOG_INPUT)-1:0] x,
    output logic                                x_ready,
    output logic [DATA_WIDTH-1:0]               out_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [LOG_INPUT-1:0]                out_index,
    output logic                                out_last,
    output logic [1:0]                          buf_count,
    output logic                                overflow
);

    localparam int N = 1 << LOG_INPUT;
    localparam logic [LOG_INPUT-1:0] LAST_IDX = LOG_INPUT'(N - 1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                      state;
    state_t                      state_nxt;
    logic [DATA_WIDTH*N-1:0]     slot [2];
    logic                        wr_ptr;
    logic                        rd_ptr;
    logic [LOG_INPUT-1:0]        idx;
    logic [LOG_INPUT-1:0]        elem_sel;
    logic [DATA_WIDTH-1:0]       head_elems [N];
    logic                        overflow_q;
    logic                        hs;
    logic                        rel_head;
    logic                        accept;
    logic                        drop;

    assign out_valid = (state != EMPTY);
    assign hs        = out_valid & out_ready;
    assign rel_head  = hs & (idx == LAST_IDX);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        drop      = 1'b0;
        case (state)
            EMPTY: begin
                if (x_valid) begin
                    accept    = 1'b1;
                    state_nxt = ONE;
                end
            end
            ONE: begin
                if (x_valid) begin
                    accept = 1'b1;
                    if (!rel_head) state_nxt = FULL;
                end else if (rel_head) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                // The head slot frees on this same edge, so its slot (== wr_ptr) takes the new vector.
                if (x_valid) begin
                    if (rel_head) accept = 1'b1;
                    else          drop   = 1'b1;
                end else if (rel_head) begin
                    state_nxt = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= EMPTY;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            idx        <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < 2; i++) slot[i] <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                slot[wr_ptr] <= x;
                wr_ptr       <= ~wr_ptr;
            end
            if (hs) idx <= idx + 1'b1;
            if (rel_head) rd_ptr <= ~rd_ptr;
            if (drop) overflow_q <= 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            head_elems[i] = slot[rd_ptr][i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign elem_sel  = (LSB_FIRST != 0) ? idx : (LAST_IDX - idx);
    assign out_data  = out_valid ? head_elems[elem_sel] : '0;
    assign out_index = idx;
    assign out_last  = out_valid & (idx == LAST_IDX);
    assign buf_count = state;
    assign x_ready   = (state != FULL);
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_bitonic_unloader.sv
// Bench for bitonic_unloader: LSB-first and MSB-first instances share stimulus and are
// compared every cycle against a queue-based model, plus directed table and corner sequences.
module tb_bitonic_unloader;

    localparam int LI = 4;
    localparam int N  = 16;
    localparam int DW = 8;
    localparam int VW = DW * N;

    logic          clk = 1'b0;
    logic          rst;
    logic          x_valid;
    logic [VW-1:0] x;
    logic          out_ready;

    logic          x_ready_l, out_valid_l, out_last_l, overflow_l;
    logic [DW-1:0] out_data_l;
    logic [LI-1:0] out_index_l;
    logic [1:0]    buf_count_l;
    logic          x_ready_m, out_valid_m, out_last_m, overflow_m;
    logic [DW-1:0] out_data_m;
    logic [LI-1:0] out_index_m;
    logic [1:0]    buf_count_m;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bitonic_unloader #(.LOG_INPUT(LI), .DATA_WIDTH(DW), .LSB_FIRST(1)) dut_lsb (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .x_ready(x_ready_l),
        .out_data(out_data_l), .out_valid(out_valid_l), .out_ready(out_ready),
        .out_index(out_index_l), .out_last(out_last_l), .buf_count(buf_count_l),
        .overflow(overflow_l)
    );

    bitonic_unloader #(.LOG_INPUT(LI), .DATA_WIDTH(DW), .LSB_FIRST(0)) dut_msb (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .x_ready(x_ready_m),
        .out_data(out_data_m), .out_valid(out_valid_m), .out_ready(out_ready),
        .out_index(out_index_m), .out_last(out_last_m), .buf_count(buf_count_m),
        .overflow(overflow_m)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of whole vectors plus a beat position in the head vector.
    logic [VW-1:0] q[$];
    int            pos = 0;
    bit            ovf = 1'b0;
    bit            mon_en = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            q.delete();
            pos = 0;
            ovf = 1'b0;
        end else begin
            if (q.size() != 0 && out_ready) begin
                pos++;
                if (pos == N) begin
                    pos = 0;
                    void'(q.pop_front());
                end
            end
            if (x_valid) begin
                if (q.size() < 2) q.push_back(x);
                else ovf = 1'b1;
            end
        end
    end

    logic [VW-1:0] head;
    logic [DW-1:0] exp_dl, exp_dm;
    bit            exp_v;

    always @(negedge clk) begin
        if (mon_en) begin
            exp_v  = (q.size() != 0);
            head   = exp_v ? q[0] : '0;
            exp_dl = exp_v ? head[pos*DW +: DW] : '0;
            exp_dm = exp_v ? head[(N-1-pos)*DW +: DW] : '0;
            chk("m_valid_l", out_valid_l, exp_v);
            chk("m_data_l",  out_data_l, exp_dl);
            chk("m_index_l", out_index_l, exp_v ? pos : 0);
            chk("m_last_l",  out_last_l, exp_v && pos == N-1);
            chk("m_count_l", buf_count_l, q.size());
            chk("m_ovf_l",   overflow_l, ovf);
            chk("m_xrdy_l",  x_ready_l, q.size() < 2);
            chk("m_valid_m", out_valid_m, exp_v);
            chk("m_data_m",  out_data_m, exp_dm);
            chk("m_last_m",  out_last_m, exp_v && pos == N-1);
            chk("m_count_m", buf_count_m, q.size());
        end
    end

    typedef struct {
        bit            rdy;
        bit            v;
        logic [LI-1:0] idx;
        logic [DW-1:0] dl;
        logic [DW-1:0] dm;
        bit            last;
    } vec_t;

    vec_t tbl[18];

    function automatic logic [VW-1:0] ramp_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = 8'(16 + i);
        return v;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = 8'($urandom);
        return v;
    endfunction

    task automatic push_vec(input logic [VW-1:0] v);
        x_valid = 1'b1;
        x       = v;
        @(negedge clk);
        x_valid = 1'b0;
        x       = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        int  beats;
        bit  idle_seen;
        bit  found;

        k = 0;
        for (int i = 0; i < N; i++) begin
            if (i == 5) begin
                tbl[k] = '{rdy: 1'b0, v: 1'b1, idx: 4'd5, dl: 8'h15, dm: 8'h1A, last: 1'b0};
                k++;
            end
            tbl[k] = '{rdy: 1'b1, v: 1'b1, idx: 4'(i), dl: 8'(16 + i), dm: 8'(31 - i), last: (i == N-1)};
            k++;
        end
        tbl[17] = '{rdy: 1'b1, v: 1'b0, idx: 4'd0, dl: 8'h00, dm: 8'h00, last: 1'b0};

        // Reset held with x_valid asserted
        rst = 1'b0; x_valid = 1'b1; x = ramp_vec(); out_ready = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk("rst_valid", out_valid_l, 1'b0);
            chk("rst_count", buf_count_l, 2'd0);
            chk("rst_ovf",   overflow_l, 1'b0);
            chk("rst_xrdy",  x_ready_l, 1'b1);
            chk("rst_data",  out_data_l, 8'h00);
            @(negedge clk);
        end
        rst = 1'b1; x_valid = 1'b0; x = '0;
        @(negedge clk);

        // Single ramp vector with one stall, both element orders
        out_ready = 1'b0;
        push_vec(ramp_vec());
        for (int e = 0; e < 18; e++) begin
            out_ready = tbl[e].rdy;
            chk("tbl_valid", out_valid_l, tbl[e].v);
            chk("tbl_index", out_index_l, tbl[e].idx);
            chk("tbl_last",  out_last_l, tbl[e].last);
            chk("tbl_data_lsb", out_data_l, tbl[e].dl);
            chk("tbl_data_msb", out_data_m, tbl[e].dm);
            chk("tbl_last_msb", out_last_m, tbl[e].last);
            @(negedge clk);
        end

        // Three back-to-back vectors while stalled: third is dropped
        do_reset();
        out_ready = 1'b0;
        push_vec(rand_vec());
        push_vec(rand_vec());
        push_vec(rand_vec());
        chk("full_count", buf_count_l, 2'd2);
        chk("full_ovf",   overflow_l, 1'b1);
        chk("full_xrdy",  x_ready_l, 1'b0);
        out_ready = 1'b1;
        beats = 0; idle_seen = 1'b0;
        for (int c = 0; c < 34; c++) begin
            if (out_valid_l && !idle_seen) beats++;
            else idle_seen = 1'b1;
            @(negedge clk);
        end
        chk("drain_beats", beats, 32);
        chk("drain_idle",  out_valid_l, 1'b0);
        chk("drain_ovf",   overflow_l, 1'b1);

        // Full buffer, new vector coincident with last beat of head
        do_reset();
        out_ready = 1'b0;
        push_vec(rand_vec());
        push_vec(rand_vec());
        out_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (out_valid_l && out_index_l == 4'(N-1)) begin
                found = 1'b1;
                break;
            end
        end
        chk("t5_wait_last", found, 1'b1);
        chk("t5_count_before", buf_count_l, 2'd2);
        push_vec(rand_vec());
        chk("t5_count_after", buf_count_l, 2'd2);
        chk("t5_ovf", overflow_l, 1'b0);
        chk("t5_index_after", out_index_l, 4'd0);
        repeat (40) @(negedge clk);
        chk("t5_idle", out_valid_l, 1'b0);

        // Random backpressure with spaced random vectors
        do_reset();
        for (int c = 0; c < 160; c++) begin
            out_ready = 1'($urandom % 2);
            if (c % 20 == 0) begin
                x_valid = 1'b1;
                x       = rand_vec();
            end else begin
                x_valid = 1'b0;
                x       = '0;
            end
            @(negedge clk);
        end
        x_valid = 1'b0; x = '0;
        for (int c = 0; c < 300; c++) begin
            out_ready = 1'($urandom % 2);
            @(negedge clk);
        end
        out_ready = 1'b1;
        repeat (40) @(negedge clk);
        chk("t6_drained", out_valid_l, 1'b0);

        // Reset in the middle of a vector
        push_vec(rand_vec());
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            out_ready = 1'($urandom % 2);
            if (out_valid_l && out_index_l == 4'd5) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("t6_wait_mid", found, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("mid_rst_valid", out_valid_l, 1'b0);
        chk("mid_rst_index", out_index_l, 4'd0);
        chk("mid_rst_data",  out_data_l, 8'h00);
        chk("mid_rst_last",  out_last_l, 1'b0);
        chk("mid_rst_count", buf_count_l, 2'd0);
        repeat (20) @(negedge clk);
        chk("mid_rst_idle", out_valid_l, 1'b0);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
